memory_access_stage: RTL and testbench
======================================

// Module: memory_access_stage
// PURPOSE
//  Memory stage of the 8-bit pipeline; consumes the execution stage's registered outputs
//  (ALU result, store-data bypass, memory controls, destination register).
//  Performs data-memory loads and stores against an internal synchronous RAM.
//  Inserts wait states through a small FSM and selects the write-back value for the
//  register-file stage.
// PARAMETERS
//  ADDR_W       8   data-memory address width; uses ans_ex[ADDR_W-1:0], depth = 2**ADDR_W
//  WAIT_CYCLES  0   extra stall cycles per memory access (0..15); 0 = single-cycle access
// PORTS
//  clk             in   1  rising-edge clock
//  reset           in   1  synchronous, active-high reset
//  ans_ex          in   8  ALU result: memory address for loads/stores, write-back value otherwise
//  B_Bypass        in   8  store data
//  mem_en_ex       in   1  1 = instruction accesses data memory
//  mem_rw_ex       in   1  1 = store, 0 = load (valid only when mem_en_ex = 1)
//  mem_mux_sel_ex  in   1  1 = write back memory data, 0 = write back ans_ex
//  RW_ex           in   5  destination register
//  ans_mem         out  8  registered write-back data
//  RW_mem          out  5  registered destination register
//  wb_valid        out  1  1 = ans_mem/RW_mem must be written to the register file this cycle
//  stall_mem       out  1  1 = upstream stages hold their outputs stable (combinational from state)
// BEHAVIOUR
//  Reset (sampled at the clock edge):
//   - ans_mem = 0, RW_mem = 0, wb_valid = 0, stall_mem = 0, FSM = IDLE, wait counter = 0.
//   - RAM contents are not cleared.
//  Non-memory op (mem_en_ex = 0):
//   - Next edge: ans_mem <= ans_ex, RW_mem <= RW_ex, wb_valid <= 1.
//   - Latency is 1 cycle. FSM stays in IDLE.
//  Memory op with WAIT_CYCLES = 0:
//   - Completes at the next edge; stall_mem stays 0.
//   - Store: mem[addr] <= B_Bypass; wb_valid <= 0; ans_mem and RW_mem hold their previous values.
//   - Load: ans_mem <= (mem_mux_sel_ex ? mem[addr] : ans_ex); RW_mem <= RW_ex; wb_valid <= 1.
//   - mem[addr] is the RAM content before this edge.
//  Memory op with WAIT_CYCLES = N > 0 (FSM IDLE -> BUSY -> IDLE):
//   - IDLE with mem_en_ex = 1: stall_mem = 1 combinationally. Next edge goes to BUSY,
//     counter <= N-1, wb_valid <= 0 (bubble).
//   - BUSY: stall_mem = 1; inputs are held stable by upstream; counter decrements each edge.
//   - BUSY with counter = 0: stall_mem = 0. The store/load completes at that edge exactly
//     as in the N = 0 case; FSM returns to IDLE.
//   - Total occupancy is N+1 cycles; stall_mem is high for N cycles.
//   - Back-to-back memory ops: IDLE is re-entered for one completion edge, then the next op
//     starts its own wait sequence.
//  Store followed by a load to the same address: the load returns the stored value (write is
//   already committed to the RAM before the load's edge).
//  Store to address 2**ADDR_W-1 is valid; upper ans_ex bits beyond ADDR_W are ignored
//   (address wraps).
//  mem_rw_ex and mem_mux_sel_ex are ignored when mem_en_ex = 0.
//  Reset mid-BUSY: access aborts, pending store is not written, FSM -> IDLE, all outputs reset.
//  Reset wins over a completing access on the same edge.
// TESTING
//  1. Reset, then non-memory op ans_ex=8'h3C, RW_ex=5'd7 -> next cycle ans_mem=8'h3C,
//     RW_mem=7, wb_valid=1.
//  2. WAIT_CYCLES=0: store B_Bypass=8'hA5 @ 8'h10, then load @ 8'h10 with RW_ex=3,
//     mem_mux_sel_ex=1 -> ans_mem=8'hA5, RW_mem=3, wb_valid=1; store cycle shows wb_valid=0.
//  3. WAIT_CYCLES=3: load @ 8'h10 -> stall_mem high 3 cycles, wb_valid=0 during the stall,
//     ans_mem=8'hA5 on the 4th edge.
//  4. ADDR_W=4: store 8'h5A @ ans_ex=8'hF2, load @ 8'h02 -> ans_mem=8'h5A (wrap).
//  5. WAIT_CYCLES=3: store 8'hFF @ 8'h20, assert reset in the 2nd BUSY cycle; afterwards
//     store 8'h11 @ 8'h20 and load it -> outputs 0 after reset, load returns 8'h11.
//     Then store 8'h00 @ 8'h21, store 8'hFF @ 8'h21 and reset before completion, load
//     8'h21 -> 8'h00.
//  6. Load with mem_mux_sel_ex=0, ans_ex=8'h10 -> ans_mem=8'h10 (bypass memory data),
//     wb_valid=1.

Source files
------------

// File: rtl/memory_access_stage.sv
// ---------------------------------------------------------------------------
// memory_access_stage
//   Memory stage of the 8-bit pipeline. Takes the execution stage's registered
//   outputs, performs loads/stores against an internal RAM, optionally inserts
//   wait states, and registers the write-back value for the register file.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   ans_ex          ALU result: memory address (loads/stores) or write-back value
//   B_Bypass        store data
//   mem_en_ex       1 = instruction accesses data memory
//   mem_rw_ex       1 = store, 0 = load (only meaningful with mem_en_ex)
//   mem_mux_sel_ex  1 = write back memory data, 0 = write back ans_ex
//   RW_ex           destination register
//   ans_mem         registered write-back data
//   RW_mem          registered destination register
//   wb_valid        ans_mem/RW_mem must be written to the register file
//   stall_mem       upstream stages hold their outputs (combinational)
//
// FSM states
//   state | meaning
//   IDLE  | ready; non-memory ops pass through, memory ops start/complete here
//   BUSY  | memory access waiting; counter counts down to the completion edge
// ---------------------------------------------------------------------------
module memory_access_stage #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ans_ex,
  input  logic [7:0] B_Bypass,
  input  logic       mem_en_ex,
  input  logic       mem_rw_ex,
  input  logic       mem_mux_sel_ex,
  input  logic [4:0] RW_ex,
  output logic [7:0] ans_mem,
  output logic [4:0] RW_mem,
  output logic       wb_valid,
  output logic       stall_mem
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
  // Counter starts at N-1 so that the Nth BUSY cycle (counter = 0) is the
  // completion cycle, giving N stall cycles and N+1 cycles of occupancy.
  localparam logic [3:0] CNT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        ans_q, ans_d;
  logic [4:0]        rw_q, rw_d;
  logic              wb_q, wb_d;
  logic              complete;
  logic              do_store;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        mem_rdata;

  logic [7:0] mem_q [DEPTH];

  // Upper address bits are dropped, so addresses wrap modulo the RAM depth.
  assign addr      = ans_ex[ADDR_W-1:0];
  assign mem_rdata = mem_q[addr];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ans_d    = ans_q;
    rw_d     = rw_q;
    wb_d     = 1'b0;
    complete = 1'b0;

    case (state_q)
      IDLE: begin
        if (!mem_en_ex) begin
          ans_d = ans_ex;
          rw_d  = RW_ex;
          wb_d  = 1'b1;
        end else if (HAS_WAIT) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end else begin
          complete = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A completing store leaves ans_mem/RW_mem untouched and emits no write-back.
    if (complete && !mem_rw_ex) begin
      ans_d = mem_mux_sel_ex ? mem_rdata : ans_ex;
      rw_d  = RW_ex;
      wb_d  = 1'b1;
    end
  end

  assign do_store  = complete && mem_rw_ex;
  assign stall_mem = ((state_q == IDLE) && mem_en_ex && HAS_WAIT) ||
                     ((state_q == BUSY) && (cnt_q != 4'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ans_q   <= 8'h00;
      rw_q    <= 5'd0;
      wb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ans_q   <= ans_d;
      rw_q    <= rw_d;
      wb_q    <= wb_d;
    end
  end

  // RAM is not cleared by reset; reset only suppresses a store on the same edge.
  always_ff @(posedge clk) begin
    if (do_store && !reset) begin
      mem_q[addr] <= B_Bypass;
    end
  end

  assign ans_mem  = ans_q;
  assign RW_mem   = rw_q;
  assign wb_valid = wb_q;

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // a_*: ADDR_W=8, WAIT_CYCLES=0
  logic       a_rst, a_en, a_rw, a_sel, a_wb, a_stall;
  logic [7:0] a_ans, a_B, a_ans_mem;
  logic [4:0] a_RW, a_RW_mem;
  // b_*: ADDR_W=8, WAIT_CYCLES=3
  logic       b_rst, b_en, b_rw, b_sel, b_wb, b_stall;
  logic [7:0] b_ans, b_B, b_ans_mem;
  logic [4:0] b_RW, b_RW_mem;
  // c_*: ADDR_W=4, WAIT_CYCLES=0
  logic       c_rst, c_en, c_rw, c_sel, c_wb, c_stall;
  logic [7:0] c_ans, c_B, c_ans_mem;
  logic [4:0] c_RW, c_RW_mem;

  memory_access_stage #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_a (
    .clk(clk), .reset(a_rst), .ans_ex(a_ans), .B_Bypass(a_B), .mem_en_ex(a_en),
    .mem_rw_ex(a_rw), .mem_mux_sel_ex(a_sel), .RW_ex(a_RW),
    .ans_mem(a_ans_mem), .RW_mem(a_RW_mem), .wb_valid(a_wb), .stall_mem(a_stall));

  memory_access_stage #(.ADDR_W(8), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .reset(b_rst), .ans_ex(b_ans), .B_Bypass(b_B), .mem_en_ex(b_en),
    .mem_rw_ex(b_rw), .mem_mux_sel_ex(b_sel), .RW_ex(b_RW),
    .ans_mem(b_ans_mem), .RW_mem(b_RW_mem), .wb_valid(b_wb), .stall_mem(b_stall));

  memory_access_stage #(.ADDR_W(4), .WAIT_CYCLES(0)) dut_c (
    .clk(clk), .reset(c_rst), .ans_ex(c_ans), .B_Bypass(c_B), .mem_en_ex(c_en),
    .mem_rw_ex(c_rw), .mem_mux_sel_ex(c_sel), .RW_ex(c_RW),
    .ans_mem(c_ans_mem), .RW_mem(c_RW_mem), .wb_valid(c_wb), .stall_mem(c_stall));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full memory op on the WAIT_CYCLES=3 instance: checks the 3-cycle
  // stall window and the bubble, returns just after the completion edge.
  task automatic op_b(input logic rw, input logic [7:0] addr, input logic [7:0] data,
                       input logic [4:0] rd, input logic sel, input string tag);
    b_en = 1'b1; b_rw = rw; b_ans = addr; b_B = data; b_RW = rd; b_sel = sel;
    #1;
    chk({tag, " stall c0"}, 32'(b_stall), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("%s stall c%0d", tag, k), 32'(b_stall), (k < 3) ? 32'd1 : 32'd0);
      chk($sformatf("%s bubble c%0d", tag, k), 32'(b_wb), 32'd0);
    end
    tick();
    b_en = 1'b0;
  endtask

  initial begin
    {a_en, a_rw, a_sel, a_ans, a_B, a_RW} = '0;
    {b_en, b_rw, b_sel, b_ans, b_B, b_RW} = '0;
    {c_en, c_rw, c_sel, c_ans, c_B, c_RW} = '0;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    chk("rst ans_mem", 32'(a_ans_mem), 32'h00);
    chk("rst RW_mem", 32'(a_RW_mem), 32'd0);
    chk("rst wb_valid", 32'(a_wb), 32'd0);
    chk("rst stall", 32'(b_stall), 32'd0);

    // Non-memory op; rw/sel set to show they are ignored without mem_en.
    a_ans = 8'h3C; a_RW = 5'd7; a_rw = 1'b1; a_sel = 1'b1; a_en = 1'b0;
    #1 chk("nonmem stall", 32'(a_stall), 32'd0);
    tick();
    chk("nonmem ans", 32'(a_ans_mem), 32'h3C);
    chk("nonmem RW", 32'(a_RW_mem), 32'd7);
    chk("nonmem wb", 32'(a_wb), 32'd1);

    // WAIT_CYCLES=0 store then load.
    a_en = 1'b1; a_rw = 1'b1; a_ans = 8'h10; a_B = 8'hA5; a_RW = 5'd9; a_sel = 1'b0;
    #1 chk("w0 store stall", 32'(a_stall), 32'd0);
    tick();
    chk("w0 store wb", 32'(a_wb), 32'd0);
    chk("w0 store ans hold", 32'(a_ans_mem), 32'h3C);
    chk("w0 store RW hold", 32'(a_RW_mem), 32'd7);
    a_rw = 1'b0; a_sel = 1'b1; a_RW = 5'd3; a_B = 8'h00;
    tick();
    chk("w0 load ans", 32'(a_ans_mem), 32'hA5);
    chk("w0 load RW", 32'(a_RW_mem), 32'd3);
    chk("w0 load wb", 32'(a_wb), 32'd1);

    // Load with memory data bypassed.
    a_sel = 1'b0; a_RW = 5'd4;
    tick();
    chk("bypass ans", 32'(a_ans_mem), 32'h10);
    chk("bypass RW", 32'(a_RW_mem), 32'd4);
    chk("bypass wb", 32'(a_wb), 32'd1);

    // Top address.
    a_rw = 1'b1; a_ans = 8'hFF; a_B = 8'h77;
    tick();
    a_rw = 1'b0; a_sel = 1'b1; a_RW = 5'd12;
    tick();
    chk("top addr ans", 32'(a_ans_mem), 32'h77);
    a_en = 1'b0;

    // ADDR_W=4 address wrap.
    c_en = 1'b1; c_rw = 1'b1; c_ans = 8'hF2; c_B = 8'h5A;
    tick();
    c_rw = 1'b0; c_sel = 1'b1; c_ans = 8'h02; c_RW = 5'd1;
    tick();
    chk("wrap ans", 32'(c_ans_mem), 32'h5A);
    chk("wrap RW", 32'(c_RW_mem), 32'd1);
    c_en = 1'b0;

    // WAIT_CYCLES=3 store and load.
    op_b(1'b1, 8'h10, 8'hA5, 5'd9, 1'b0, "w3 store");
    chk("w3 store wb", 32'(b_wb), 32'd0);
    chk("w3 store ans hold", 32'(b_ans_mem), 32'h00);
    op_b(1'b0, 8'h10, 8'h00, 5'd3, 1'b1, "w3 load");
    chk("w3 load ans", 32'(b_ans_mem), 32'hA5);
    chk("w3 load RW", 32'(b_RW_mem), 32'd3);
    chk("w3 load wb", 32'(b_wb), 32'd1);

    // Reset in the 2nd BUSY cycle of a store.
    b_en = 1'b1; b_rw = 1'b1; b_ans = 8'h20; b_B = 8'hFF; b_RW = 5'd2;
    tick(); tick();
    chk("abort busy stall", 32'(b_stall), 32'd1);
    b_rst = 1'b1; b_en = 1'b0;
    tick();
    b_rst = 1'b0;
    chk("abort ans", 32'(b_ans_mem), 32'h00);
    chk("abort RW", 32'(b_RW_mem), 32'd0);
    chk("abort wb", 32'(b_wb), 32'd0);
    chk("abort stall", 32'(b_stall), 32'd0);

    op_b(1'b1, 8'h20, 8'h11, 5'd2, 1'b0, "post store");
    op_b(1'b0, 8'h20, 8'h00, 5'd5, 1'b1, "post load");
    chk("post load ans", 32'(b_ans_mem), 32'h11);
    chk("post load RW", 32'(b_RW_mem), 32'd5);

    // Reset on the completing edge of a store: the store must not land.
    op_b(1'b1, 8'h21, 8'h00, 5'd2, 1'b0, "st21 a");
    b_en = 1'b1; b_rw = 1'b1; b_ans = 8'h21; b_B = 8'hFF;
    tick(); tick(); tick();
    chk("complete-edge stall", 32'(b_stall), 32'd0);
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0; b_en = 1'b0;
    chk("reset-wins wb", 32'(b_wb), 32'd0);
    chk("reset-wins ans", 32'(b_ans_mem), 32'h00);
    op_b(1'b0, 8'h21, 8'h00, 5'd6, 1'b1, "ld21");
    chk("ld21 ans", 32'(b_ans_mem), 32'h00);
    chk("ld21 RW", 32'(b_RW_mem), 32'd6);
    chk("ld21 wb", 32'(b_wb), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
